// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Groups the requester handshake and the UART transmitter hand-off signals
// of uart_tx_arbiter into one bundle.
//
// Parameters
//   N_REQ : number of requesters (2..8)
//   DBIT  : data bits per character
//
// Signals (names follow the arbiter's port list)
//   i_req_valid    [N_REQ]      per-requester character pending
//   i_req_data     [N_REQ*DBIT] requester k data in bits [k*DBIT +: DBIT]
//   o_req_ready    [N_REQ]      one-hot, one-cycle accept pulse
//   o_tx_start                  one-cycle start pulse to the transmitter
//   o_tx_data      [DBIT]       character presented to the transmitter
//   i_tx_done_tick              transmitter end-of-stop-bit pulse
//   o_busy                      high whenever the arbiter is not idle
//   o_grant_id     [3]          current or last granted requester
//   o_timeout                   one-cycle watchdog abort pulse
//
// Modports
//   slave  : the arbiter side
//   master : the requester / transmitter side
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DBIT  = 8
);
    logic [N_REQ-1:0]      i_req_valid;
    logic [N_REQ*DBIT-1:0] i_req_data;
    logic [N_REQ-1:0]      o_req_ready;
    logic                  o_tx_start;
    logic [DBIT-1:0]       o_tx_data;
    logic                  i_tx_done_tick;
    logic                  o_busy;
    logic [2:0]            o_grant_id;
    logic                  o_timeout;

    modport slave (
        input  i_req_valid, i_req_data, i_tx_done_tick,
        output o_req_ready, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout
    );

    modport master (
        output i_req_valid, i_req_data, i_tx_done_tick,
        input  o_req_ready, o_tx_start, o_tx_data, o_busy, o_grant_id, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter that lets N_REQ requesters share one UART transmitter.
// One character is handed over per grant: IDLE picks the first valid
// requester at or after the round-robin pointer, ISSUE pulses tx_start and
// the winner's ready for one cycle, WAIT holds until the transmitter reports
// the end of the stop bit. The pointer then moves past the winner.
//
// Parameters
//   N_REQ       : number of requesters (2..8)
//   DBIT        : data bits per character
//   TIMEOUT_CYC : WAIT watchdog limit in clocks (20-bit counter)
//
// Ports
//   i_clock   : single clock, rising edge
//   i_reset_n : asynchronous active-low reset
//   bus       : uart_tx_arbiter_if.slave (requesters + transmitter hand-off)
//
// Build option
//   UART_TX_ARB_TIMEOUT_EN : when defined, a watchdog aborts a WAIT that
//   lasts TIMEOUT_CYC cycles, pulses o_timeout and advances the pointer as
//   if the character had completed. When undefined, no counter exists and
//   o_timeout is constant 0.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DBIT        = 8,
    parameter int TIMEOUT_CYC = 1048575
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0]       LAST_ID = 3'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT = N_REQ'(1);

    state_t           state;
    logic [2:0]       ptr;
    logic [2:0]       grant_sel;
    logic             any_valid;
    logic [2:0]       next_ptr;

    logic             tx_start_q;
    logic [N_REQ-1:0] req_ready_q;
    logic [DBIT-1:0]  tx_data_q;
    logic [2:0]       grant_id_q;

    // Round-robin search: walk from the highest offset down so the lowest
    // offset from ptr (the first valid index at or after ptr) wins.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        grant_sel = 3'd0;
        any_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % N_REQ;
            if (bus.i_req_valid[idx]) begin
                grant_sel = 3'(idx);
                any_valid = 1'b1;
            end
        end
    end

    // Pointer moves just past the requester that was served.
    assign next_ptr = (grant_id_q == LAST_ID) ? 3'd0 : grant_id_q + 3'd1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_CYC);

    logic [19:0] wd_cnt;
    logic        timeout_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            tx_data_q   <= '0;
            grant_id_q  <= 3'd0;
            timeout_q   <= 1'b0;
            wd_cnt      <= 20'd0;
        end else begin
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            timeout_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        tx_data_q   <= bus.i_req_data[grant_sel*DBIT +: DBIT];
                        grant_id_q  <= grant_sel;
                        tx_start_q  <= 1'b1;
                        req_ready_q <= ONE_HOT << grant_sel;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= 20'd0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (bus.i_tx_done_tick) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end else if (wd_cnt == TIMEOUT_LIM - 20'd1) begin
                        // TIMEOUT_CYC-th WAIT cycle without done: abort.
                        timeout_q <= 1'b1;
                        ptr       <= next_ptr;
                        state     <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others regardless of order.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            ptr         <= 3'd0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            tx_data_q   <= '0;
            grant_id_q  <= 3'd0;
        end else begin
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        tx_data_q   <= bus.i_req_data[grant_sel*DBIT +: DBIT];
                        grant_id_q  <= grant_sel;
                        tx_start_q  <= 1'b1;
                        req_ready_q <= ONE_HOT << grant_sel;
                        state       <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (bus.i_tx_done_tick) begin
                        ptr   <= next_ptr;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_tx_start  = tx_start_q;
    assign bus.o_req_ready = req_ready_q;
    assign bus.o_tx_data   = tx_data_q;
    assign bus.o_grant_id  = grant_id_q;
    assign bus.o_busy      = (state != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (legal 2..8).
REQ-002 The block SHALL have parameter DBIT, default 8, data bits per character.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1048575, WAIT watchdog limit in clocks; 20-bit counter.
REQ-004 The block SHALL have i_clock  input  1  single clock; all state updates on rising edge.
REQ-005 The block SHALL have i_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have i_req_valid  input  N_REQ  per-requester character pending.
REQ-007 The block SHALL have i_req_data  input  N_REQ*DBIT  requester k data in bits [k*DBIT +: DBIT].
REQ-008 The block SHALL have o_req_ready  output  N_REQ  one-hot one-cycle accept pulse.
REQ-009 The block SHALL have o_tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 The block SHALL have o_tx_data  output  DBIT  character presented to the transmitter.
REQ-011 The block SHALL have i_tx_done_tick  input  1  transmitter end-of-stop-bit pulse.
REQ-012 The block SHALL have o_busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have o_grant_id  output  3  index of the current or last granted requester.
REQ-014 The block SHALL have o_timeout  output  1  one-cycle watchdog abort pulse; constant 0 when not compiled in.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-016 In IDLE with any i_req_valid bit high at a rising edge, the block SHALL, at that edge: choose grant g as the first valid index searching upward from pointer ptr with wrap modulo N_REQ; load o_tx_data from slice g; set o_grant_id=g; go to ISSUE.
REQ-017 In ISSUE, for exactly one cycle, o_tx_start SHALL be 1 and o_req_ready[g] SHALL be 1, all other ready bits 0; next state WAIT.
REQ-018 A requester SHALL hold valid and data stable until its ready pulse; the transfer completes in the ready cycle; latency from valid sampled to o_tx_start high is 1 clock.
REQ-019 In WAIT, i_tx_done_tick=1 SHALL set ptr=(g+1) mod N_REQ and return to IDLE; at least one IDLE cycle separates consecutive grants.
REQ-020 i_tx_done_tick SHALL be ignored in IDLE and ISSUE; i_req_valid changes SHALL be ignored in ISSUE and WAIT.
REQ-021 A requester deasserting valid before grant SHALL simply not be granted; no state is kept per requester.
REQ-022 o_tx_start, o_req_ready, o_tx_data, o_grant_id and o_timeout SHALL be registered outputs; o_busy SHALL be decoded from state.
REQ-023 A single requester continuously valid SHALL be granted back-to-back, once per character, with ptr advancing past it each time.

Reset
REQ-024 On i_reset_n low, immediately and independent of the clock: state=IDLE, ptr=0, o_tx_start=0, o_req_ready=0, o_tx_data=0, o_grant_id=0, o_timeout=0, watchdog counter=0.
REQ-025 Reset during WAIT SHALL discard the in-flight grant without any ready pulse; the transmitter is reset by its own reset.

Configuration
REQ-026 With macro UART_TX_ARB_TIMEOUT_EN defined: the counter clears on entry to WAIT and increments each WAIT cycle; reaching TIMEOUT_CYC without done returns to IDLE, pulses o_timeout for 1 cycle and advances ptr as for done.
REQ-027 Without UART_TX_ARB_TIMEOUT_EN: no counter is built, o_timeout is tied 0, and WAIT exits only on i_tx_done_tick.

Verification
REQ-028 Reset: i_reset_n=0 asserted mid-cycle during WAIT -> all outputs 0 before the next edge, state IDLE, ptr=0.
REQ-029 Single request: valid=4'b0100, data[23:16]=8'hA5 -> o_tx_data=8'hA5, o_grant_id=2, ready=4'b0100 and tx_start both high for 1 cycle; busy until done pulse.
REQ-030 Round-robin: valid=4'b1111 held, done 5 cycles after each start -> grant order 0,1,2,3,0.
REQ-031 Wrap: ptr=3 after a grant to 2, valid=4'b0011 -> grant 0, then 1.
REQ-032 Done ignored: i_tx_done_tick pulsed in IDLE with no valid -> no state change; pulsed in ISSUE -> still enters WAIT.
REQ-033 Timeout (macro on, TIMEOUT_CYC=16): grant, no done -> o_timeout high for 1 cycle exactly 16 WAIT cycles after entry, then IDLE; macro off -> remains in WAIT.
